ula_arbiter: RTL and testbench

- Shares one ula instance (8-bit ALU, 3-bit opcode) between two requesters.
- Round-robin arbitration with a valid/ready handshake.
- Latches the granted operands and holds them stable on the ula inputs for the full operation.
- Captures ula_s after a configurable latency and returns it to the owning requester with a one-cycle response pulse.
- Sits between the ula datapath and its two users.

---
 rtl/ula_arbiter_if.sv | 50 +++++
 rtl/ula_arbiter.sv | 117 +++++++++++
 tb/tb_ula_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_arbiter_if.sv
// Bundle of the two requester ports, the shared response and the ula datapath
// connection, as seen by the arbiter (slave) and by its surroundings (master).
interface ula_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_result;

    logic [WIDTH-1:0] ula_a;
    logic [WIDTH-1:0] ula_b;
    logic [OPW-1:0]   ula_opcode;
    logic [WIDTH-1:0] ula_s;

    logic             busy;
    logic             last_grant;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  ula_s,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result,
        output ula_a, ula_b, ula_opcode,
        output busy, last_grant
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output ula_s,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result,
        input  ula_a, ula_b, ula_opcode,
        input  busy, last_grant
    );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin sharing of one ula between two requesters: grants in IDLE, holds
// the granted operands through EXEC, returns the captured result in DONE.
module ula_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int LAT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    ula_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT_C = 3'(LAT);

    state_t           state_reg;
    logic [2:0]       cnt_reg;
    logic             owner_reg;
    logic             last_grant_reg;
    logic [WIDTH-1:0] ula_a_reg;
    logic [WIDTH-1:0] ula_b_reg;
    logic [OPW-1:0]   ula_op_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic [1:0]       rsp_valid_reg;

    logic [1:0]       req_valid;
    logic [1:0]       ready;
    logic             sel;
    logic             grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OPW-1:0]   sel_op;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    // On a tie the requester that did not win last time is preferred.
    always_comb begin
        sel = 1'b0;
        if (&req_valid) begin
            sel = ~last_grant_reg;
        end else if (req_valid[1]) begin
            sel = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = (state_reg == IDLE) && req_valid[gi] && (sel == 1'(gi));
        end
    endgenerate

    assign grant  = |ready;
    assign sel_a  = sel ? bus.req1_a  : bus.req0_a;
    assign sel_b  = sel ? bus.req1_b  : bus.req0_b;
    assign sel_op = sel ? bus.req1_op : bus.req0_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            ula_a_reg      <= '0;
            ula_b_reg      <= '0;
            ula_op_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_valid_reg  <= '0;
        end else begin
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        ula_a_reg      <= sel_a;
                        ula_b_reg      <= sel_b;
                        ula_op_reg     <= sel_op;
                        owner_reg      <= sel;
                        last_grant_reg <= sel;
                        cnt_reg        <= '0;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == LAT_C) begin
                        rsp_result_reg           <= bus.ula_s;
                        rsp_valid_reg[owner_reg] <= 1'b1;
                        state_reg                <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.rsp0_valid = rsp_valid_reg[0];
    assign bus.rsp1_valid = rsp_valid_reg[1];
    assign bus.rsp_result = rsp_result_reg;
    assign bus.ula_a      = ula_a_reg;
    assign bus.ula_b      = ula_b_reg;
    assign bus.ula_opcode = ula_op_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.last_grant = last_grant_reg;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: one LAT=1 instance behind a registered ula
// model and one LAT=0 instance behind a combinational ula model.
module tb_ula_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ula_arbiter_if #(.WIDTH(8), .OPW(3)) ifa ();
    ula_arbiter_if #(.WIDTH(8), .OPW(3)) ifb ();

    ula_arbiter #(.WIDTH(8), .OPW(3), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(ifa));
    ula_arbiter #(.WIDTH(8), .OPW(3), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(ifb));

    function automatic logic [7:0] ula_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    ula_f = a + b;
            3'd1:    ula_f = a - b;
            3'd2:    ula_f = a & b;
            3'd3:    ula_f = a | b;
            3'd4:    ula_f = a ^ b;
            3'd5:    ula_f = ~a;
            3'd6:    ula_f = a << 1;
            default: ula_f = a >> 1;
        endcase
    endfunction

    // One-cycle ula for the LAT=1 instance, combinational ula for LAT=0.
    always @(posedge clk) ifa.ula_s <= ula_f(ifa.ula_a, ifa.ula_b, ifa.ula_opcode);
    always_comb ifb.ula_s = ula_f(ifb.ula_a, ifb.ula_b, ifb.ula_opcode);

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op);
        ifa.req0_valid = v;
        ifa.req0_a     = a;
        ifa.req0_b     = b;
        ifa.req0_op    = op;
    endtask

    task automatic set_req1(input logic v, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op);
        ifa.req1_valid = v;
        ifa.req1_a     = a;
        ifa.req1_b     = b;
        ifa.req1_op    = op;
    endtask

    int         g_idx[$];
    int         g_cyc[$];
    int         r_idx[$];
    int         r_cyc[$];
    logic [7:0] r_val[$];
    int         both_rsp;
    int         pulses;
    int         exp_g[4];
    int         exp_r[4];

    initial begin
        set_req0(1'b0, 8'd0, 8'd0, 3'd0);
        set_req1(1'b0, 8'd0, 8'd0, 3'd0);
        ifb.req0_valid = 1'b0; ifb.req0_a = '0; ifb.req0_b = '0; ifb.req0_op = '0;
        ifb.req1_valid = 1'b0; ifb.req1_a = '0; ifb.req1_b = '0; ifb.req1_op = '0;

        // ---- reset state ----
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_busy",       ifa.busy,       0);
        check("rst_last_grant", ifa.last_grant, 1);
        check("rst_ula_a",      ifa.ula_a,      0);
        check("rst_rsp_result", ifa.rsp_result, 0);
        check("rst_rsp0",       ifa.rsp0_valid, 0);

        // ---- 1: single add on req0 ----
        set_req0(1'b1, 8'd5, 8'd10, 3'd0);
        #1;
        check("t1_ready0", ifa.req0_ready, 1);
        check("t1_ready1", ifa.req1_ready, 0);
        tick();
        set_req0(1'b0, 8'd0, 8'd0, 3'd0);
        check("t1_busy_c1", ifa.busy, 1);
        check("t1_ula_a",   ifa.ula_a, 5);
        check("t1_rsp0_c1", ifa.rsp0_valid, 0);
        tick();
        check("t1_busy_c2", ifa.busy, 1);
        tick();
        check("t1_busy_c3", ifa.busy, 1);
        check("t1_rsp0_c3", ifa.rsp0_valid, 1);
        check("t1_rsp1_c3", ifa.rsp1_valid, 0);
        check("t1_result",  ifa.rsp_result, 15);
        tick();
        check("t1_busy_c4", ifa.busy, 0);
        check("t1_rsp0_c4", ifa.rsp0_valid, 0);

        // ---- 2: tie right after reset ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req0(1'b1, 8'd5, 8'd10, 3'd0);
        set_req1(1'b1, 8'd5, 8'd10, 3'd1);
        #1;
        check("t2_ready0", ifa.req0_ready, 1);
        check("t2_ready1", ifa.req1_ready, 0);
        tick();
        set_req0(1'b0, 8'd0, 8'd0, 3'd0);
        tick(); tick();
        check("t2_rsp0",    ifa.rsp0_valid, 1);
        check("t2_result0", ifa.rsp_result, 15);
        tick();
        check("t2_ready1_idle", ifa.req1_ready, 1);
        tick();
        set_req1(1'b0, 8'd0, 8'd0, 3'd0);
        tick(); tick();
        check("t2_rsp1",    ifa.rsp1_valid, 1);
        check("t2_rsp0_lo", ifa.rsp0_valid, 0);
        check("t2_result1", ifa.rsp_result, 251);
        tick();
        check("t2_last_grant", ifa.last_grant, 1);

        // ---- 3: both requesters held valid for four operations ----
        set_req0(1'b1, 8'd1, 8'd2, 3'd0);
        set_req1(1'b1, 8'd9, 8'd4, 3'd1);
        #1;
        both_rsp = 0;
        for (int c = 0; c < 16; c++) begin
            if (ifa.req0_ready) begin g_idx.push_back(0); g_cyc.push_back(c); end
            if (ifa.req1_ready) begin g_idx.push_back(1); g_cyc.push_back(c); end
            if (ifa.rsp0_valid && ifa.rsp1_valid) both_rsp++;
            else if (ifa.rsp0_valid) begin r_idx.push_back(0); r_cyc.push_back(c); r_val.push_back(ifa.rsp_result); end
            else if (ifa.rsp1_valid) begin r_idx.push_back(1); r_cyc.push_back(c); r_val.push_back(ifa.rsp_result); end
            tick();
        end
        set_req0(1'b0, 8'd0, 8'd0, 3'd0);
        set_req1(1'b0, 8'd0, 8'd0, 3'd0);
        exp_g = '{0, 1, 0, 1};
        exp_r = '{3, 5, 3, 5};
        check("t3_grants", g_idx.size(), 4);
        check("t3_rsps",   r_idx.size(), 4);
        check("t3_both",   both_rsp, 0);
        for (int k = 0; k < 4; k++) begin
            if (k < g_idx.size()) begin
                check($sformatf("t3_gidx%0d", k), g_idx[k], exp_g[k]);
                check($sformatf("t3_gcyc%0d", k), g_cyc[k], 4 * k);
            end
            if (k < r_idx.size()) begin
                check($sformatf("t3_ridx%0d", k), r_idx[k], exp_g[k]);
                check($sformatf("t3_rcyc%0d", k), r_cyc[k], 4 * k + 3);
                check($sformatf("t3_rval%0d", k), r_val[k], exp_r[k]);
            end
        end

        // ---- 4: operands ignored after the handshake ----
        set_req0(1'b1, 8'd8, 8'd3, 3'd0);
        #1;
        check("t4_ready0", ifa.req0_ready, 1);
        tick();
        set_req0(1'b0, 8'd100, 8'd50, 3'd1);
        check("t4_ula_a_c1", ifa.ula_a, 8);
        tick();
        check("t4_ula_a_c2", ifa.ula_a, 8);
        check("t4_ula_op_c2", ifa.ula_opcode, 0);
        tick();
        check("t4_ula_a_done", ifa.ula_a, 8);
        check("t4_rsp0",   ifa.rsp0_valid, 1);
        check("t4_result", ifa.rsp_result, 11);
        tick();
        check("t4_ula_a_idle", ifa.ula_a, 8);

        // ---- 5: reset in the middle of a req1 operation ----
        set_req1(1'b1, 8'd7, 8'd2, 3'd4);
        #1;
        check("t5_ready1", ifa.req1_ready, 1);
        tick();
        set_req1(1'b0, 8'd0, 8'd0, 3'd0);
        check("t5_ula_a_exec", ifa.ula_a, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy",       ifa.busy,       0);
        check("t5_ula_a",      ifa.ula_a,      0);
        check("t5_ula_b",      ifa.ula_b,      0);
        check("t5_ula_op",     ifa.ula_opcode, 0);
        check("t5_last_grant", ifa.last_grant, 1);
        check("t5_rsp_result", ifa.rsp_result, 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (ifa.rsp0_valid || ifa.rsp1_valid) pulses++;
            tick();
        end
        check("t5_no_pulse", pulses, 0);
        set_req0(1'b1, 8'd1, 8'd1, 3'd0);
        set_req1(1'b1, 8'd3, 8'd3, 3'd0);
        #1;
        check("t5_tie_ready0", ifa.req0_ready, 1);
        check("t5_tie_ready1", ifa.req1_ready, 0);
        tick();
        set_req0(1'b0, 8'd0, 8'd0, 3'd0);
        set_req1(1'b0, 8'd0, 8'd0, 3'd0);
        tick(); tick();
        check("t5_rsp0",   ifa.rsp0_valid, 1);
        check("t5_result", ifa.rsp_result, 2);
        tick();

        // ---- reset and handshake on the same edge: reset wins ----
        set_req0(1'b1, 8'd77, 8'd1, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req0(1'b0, 8'd0, 8'd0, 3'd0);
        #1;
        check("rh_busy",       ifa.busy,       0);
        check("rh_last_grant", ifa.last_grant, 1);
        check("rh_ula_a",      ifa.ula_a,      0);
        tick();

        // ---- 6: LAT=0 instance, add with 8-bit wrap ----
        ifb.req1_valid = 1'b1; ifb.req1_a = 8'd200; ifb.req1_b = 8'd100; ifb.req1_op = 3'd0;
        #1;
        check("t6_ready1", ifb.req1_ready, 1);
        tick();
        ifb.req1_valid = 1'b0;
        check("t6_busy_c1", ifb.busy, 1);
        check("t6_rsp1_c1", ifb.rsp1_valid, 0);
        tick();
        check("t6_rsp1_c2", ifb.rsp1_valid, 1);
        check("t6_rsp0_c2", ifb.rsp0_valid, 0);
        check("t6_result",  ifb.rsp_result, 44);
        tick();
        check("t6_busy_c3", ifb.busy, 0);
        check("t6_rsp1_c3", ifb.rsp1_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
